// File: rtl/eth_tx_arb_pkg.sv
// Shared types for the 10G MAC TX packet arbiter: arbiter state, stream beat and
// the round-robin pick used at every arbitration point.
package eth_tx_arb_pkg;

    localparam int unsigned ETH_TX_DATA_W  = 32;
    localparam int unsigned ETH_TX_EMPTY_W = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPkt0 = 2'd1,
        StPkt1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ETH_TX_DATA_W-1:0]  data;
        logic                      sop;
        logic                      eop;
        logic [ETH_TX_EMPTY_W-1:0] empty;
        logic                      error;
    } tx_beat_t;

    // On a tie the requester that did not send the previous packet wins.
    function automatic arb_state_t arb_pick(input logic req0, input logic req1,
                                            input logic last);
        arb_state_t nxt;
        if (req0 && req1) begin
            nxt = last ? StPkt0 : StPkt1;
        end else if (req0) begin
            nxt = StPkt0;
        end else if (req1) begin
            nxt = StPkt1;
        end else begin
            nxt = StIdle;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/eth_st_skid_buf.sv
// Two-entry registered skid buffer for tx_beat_t. Input ready depends only on
// occupancy, so downstream ready never reaches the upstream side combinationally.
module eth_st_skid_buf
    import eth_tx_arb_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  tx_beat_t in_beat_i,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    output tx_beat_t out_beat_o,
    output logic     out_valid_o,
    input  logic     out_ready_i
);

    logic [1:0] count_q, count_d;
    tx_beat_t   head_q, head_d;
    tx_beat_t   tail_q, tail_d;
    logic       push;
    logic       pop;

    // Occupancy and entry movement; the head entry always drives the output.
    always_comb begin
        in_ready_o = (count_q != 2'd2);
        push       = in_valid_i && in_ready_o;
        pop        = (count_q != 2'd0) && out_ready_i;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        case (count_q)
            2'd1: begin
                if (pop && push) begin
                    head_d = in_beat_i;
                end else if (pop) begin
                    count_d = 2'd0;
                end else if (push) begin
                    tail_d  = in_beat_i;
                    count_d = 2'd2;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: begin
                if (push) begin
                    head_d  = in_beat_i;
                    count_d = 2'd1;
                end
            end
        endcase
        out_beat_o  = head_q;
        out_valid_o = (count_q != 2'd0);
    end

    // Buffer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/eth_10g_tx_arbiter.sv
// Packet-granular round-robin arbiter merging two Avalon-ST sources onto the
// 10G MAC TX stream through a 2-entry skid buffer.
// Optional statistics ports are compiled in with ETH_TX_ARB_STATS_EN.
module eth_10g_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = ETH_TX_DATA_W,
    parameter int unsigned EMPTY_W = ETH_TX_EMPTY_W
) (
    input  logic               tx_312_5_clk,
    input  logic               tx_rst_n,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic               in0_startofpacket,
    input  logic               in0_endofpacket,
    input  logic [EMPTY_W-1:0] in0_empty,
    input  logic               in0_error,
    input  logic               in0_valid,
    output logic               in0_ready,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic               in1_startofpacket,
    input  logic               in1_endofpacket,
    input  logic [EMPTY_W-1:0] in1_empty,
    input  logic               in1_error,
    input  logic               in1_valid,
    output logic               in1_ready,
    output logic [DATA_W-1:0]  avalon_st_tx_data,
    output logic               avalon_st_tx_startofpacket,
    output logic               avalon_st_tx_endofpacket,
    output logic [EMPTY_W-1:0] avalon_st_tx_empty,
    output logic               avalon_st_tx_error,
    output logic               avalon_st_tx_valid,
`ifdef ETH_TX_ARB_STATS_EN
    output logic [31:0]        stat_pkt0,
    output logic [31:0]        stat_pkt1,
    output logic [15:0]        stat_drop,
`endif
    input  logic               avalon_st_tx_ready
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       req0, req1;
    logic       skid_in_ready;
    logic       push_valid;
    tx_beat_t   beat0, beat1, push_beat, head_beat;
    logic       drop0, drop1;
    logic       eop0, eop1;

    // Grant, readies, discard detection and same-cycle re-arbitration on eop.
    always_comb begin
        beat0      = '{data: in0_data, sop: in0_startofpacket, eop: in0_endofpacket,
                       empty: in0_empty, error: in0_error};
        beat1      = '{data: in1_data, sop: in1_startofpacket, eop: in1_endofpacket,
                       empty: in1_empty, error: in1_error};
        req0       = in0_valid && in0_startofpacket;
        req1       = in1_valid && in1_startofpacket;
        in0_ready  = 1'b0;
        in1_ready  = 1'b0;
        push_valid = 1'b0;
        push_beat  = beat0;
        state_d    = state_q;
        last_d     = last_q;
        drop0      = 1'b0;
        drop1      = 1'b0;
        eop0       = 1'b0;
        eop1       = 1'b0;
        case (state_q)
            StPkt0: begin
                in0_ready  = skid_in_ready;
                push_valid = in0_valid;
                drop1      = in1_valid && !in1_startofpacket;
                if (in0_valid && skid_in_ready && in0_endofpacket) begin
                    eop0    = 1'b1;
                    last_d  = 1'b0;
                    state_d = arb_pick(req0, req1, 1'b0);
                end
            end
            StPkt1: begin
                in1_ready  = skid_in_ready;
                push_valid = in1_valid;
                push_beat  = beat1;
                drop0      = in0_valid && !in0_startofpacket;
                if (in1_valid && skid_in_ready && in1_endofpacket) begin
                    eop1    = 1'b1;
                    last_d  = 1'b1;
                    state_d = arb_pick(req0, req1, 1'b1);
                end
            end
            default: begin
                drop0   = in0_valid && !in0_startofpacket;
                drop1   = in1_valid && !in1_startofpacket;
                state_d = arb_pick(req0, req1, last_q);
            end
        endcase
        // Non-sop beats from an ungranted source are swallowed.
        if (drop0) in0_ready = 1'b1;
        if (drop1) in1_ready = 1'b1;
    end

    // Arbiter state; last starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge tx_312_5_clk) begin
        if (!tx_rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    eth_st_skid_buf u_skid (
        .clk_i       (tx_312_5_clk),
        .rst_ni      (tx_rst_n),
        .in_beat_i   (push_beat),
        .in_valid_i  (push_valid),
        .in_ready_o  (skid_in_ready),
        .out_beat_o  (head_beat),
        .out_valid_o (avalon_st_tx_valid),
        .out_ready_i (avalon_st_tx_ready)
    );

    assign avalon_st_tx_data          = head_beat.data;
    assign avalon_st_tx_startofpacket = head_beat.sop;
    assign avalon_st_tx_endofpacket   = head_beat.eop;
    assign avalon_st_tx_empty         = head_beat.empty;
    assign avalon_st_tx_error         = head_beat.error;

`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] stat_pkt0_q, stat_pkt0_d;
    logic [31:0] stat_pkt1_q, stat_pkt1_d;
    logic [15:0] stat_drop_q, stat_drop_d;
    logic [16:0] drop_sum;

    // Wrapping packet counts; drop count saturates (up to two drops per cycle).
    always_comb begin
        stat_pkt0_d = stat_pkt0_q + {31'd0, eop0};
        stat_pkt1_d = stat_pkt1_q + {31'd0, eop1};
        drop_sum    = {1'b0, stat_drop_q} + {16'd0, drop0} + {16'd0, drop1};
        stat_drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Statistics registers.
    always_ff @(posedge tx_312_5_clk) begin
        if (!tx_rst_n) begin
            stat_pkt0_q <= '0;
            stat_pkt1_q <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_pkt0_q <= stat_pkt0_d;
            stat_pkt1_q <= stat_pkt1_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_pkt0 = stat_pkt0_q;
    assign stat_pkt1 = stat_pkt1_q;
    assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_eth_10g_tx_arbiter.sv
// Bench for eth_10g_tx_arbiter: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_eth_10g_tx_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        error;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] in0_data, in1_data;
    logic        in0_startofpacket, in1_startofpacket;
    logic        in0_endofpacket, in1_endofpacket;
    logic [1:0]  in0_empty, in1_empty;
    logic        in0_error, in1_error;
    logic        in0_valid, in1_valid;
    logic        in0_ready, in1_ready;
    logic [31:0] avalon_st_tx_data;
    logic        avalon_st_tx_startofpacket, avalon_st_tx_endofpacket;
    logic [1:0]  avalon_st_tx_empty;
    logic        avalon_st_tx_error, avalon_st_tx_valid, avalon_st_tx_ready;
`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] stat_pkt0, stat_pkt1;
    logic [15:0] stat_drop;
`endif

    eth_10g_tx_arbiter dut (
        .tx_312_5_clk               (clk),
        .tx_rst_n                   (rst_n),
        .in0_data                   (in0_data),
        .in0_startofpacket          (in0_startofpacket),
        .in0_endofpacket            (in0_endofpacket),
        .in0_empty                  (in0_empty),
        .in0_error                  (in0_error),
        .in0_valid                  (in0_valid),
        .in0_ready                  (in0_ready),
        .in1_data                   (in1_data),
        .in1_startofpacket          (in1_startofpacket),
        .in1_endofpacket            (in1_endofpacket),
        .in1_empty                  (in1_empty),
        .in1_error                  (in1_error),
        .in1_valid                  (in1_valid),
        .in1_ready                  (in1_ready),
        .avalon_st_tx_data          (avalon_st_tx_data),
        .avalon_st_tx_startofpacket (avalon_st_tx_startofpacket),
        .avalon_st_tx_endofpacket   (avalon_st_tx_endofpacket),
        .avalon_st_tx_empty         (avalon_st_tx_empty),
        .avalon_st_tx_error         (avalon_st_tx_error),
        .avalon_st_tx_valid         (avalon_st_tx_valid),
`ifdef ETH_TX_ARB_STATS_EN
        .stat_pkt0                  (stat_pkt0),
        .stat_pkt1                  (stat_pkt1),
        .stat_drop                  (stat_drop),
`endif
        .avalon_st_tx_ready         (avalon_st_tx_ready)
    );

    int checks = 0;
    int errors = 0;

    // Model: owner of the current packet (-1 none), tie-break memory, MAC-side queue.
    int          g = -1;
    bit          last = 1'b1;
    beat_t       mq[$];
    logic [31:0] m_pkt0 = '0, m_pkt1 = '0;
    logic [15:0] m_drop = '0;

    // Source queues and per-test bookkeeping.
    beat_t s0[$], s1[$];
    beat_t log_b[$];
    int    log_c[$];
    logic  rh0[$];
    int    rel;
    int    start0, start1;
    bit    mac_pat[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h rel=%0d t=%0t", name, act, exp, rel, $time);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1, input bit lst);
        if (r0 && r1) return lst ? 0 : 1;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic add_pkt(input int n, input logic [31:0] base, input int len,
                           input logic [1:0] emp, input logic err);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = base + 32'(i);
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.empty = (i == len - 1) ? emp : 2'd0;
            b.error = err;
            if (n == 0) s0.push_back(b);
            else s1.push_back(b);
        end
    endtask

    task automatic start_test();
        rel = 0;
        log_b.delete();
        log_c.delete();
        rh0.delete();
        start0 = 0;
        start1 = 0;
        for (int i = 0; i < 8; i++) mac_pat[i] = 1'b1;
    endtask

    // One clock: drive, compare DUT against model, then advance the model.
    task automatic step(input bit rnd);
        beat_t b0, b1;
        bit    e0, e1, r0, r1, a0, a1;
        @(negedge clk);
        e0 = (s0.size() > 0) && (rnd ? ($urandom_range(0, 3) != 0) : (rel >= start0));
        e1 = (s1.size() > 0) && (rnd ? ($urandom_range(0, 3) != 0) : (rel >= start1));
        b0 = e0 ? s0[0] : beat_t'({$urandom, 5'($urandom)});
        b1 = e1 ? s1[0] : beat_t'({$urandom, 5'($urandom)});
        {in0_data, in0_startofpacket, in0_endofpacket, in0_empty, in0_error} = b0;
        {in1_data, in1_startofpacket, in1_endofpacket, in1_empty, in1_error} = b1;
        in0_valid = e0;
        in1_valid = e1;
        avalon_st_tx_ready = rnd ? ($urandom_range(0, 3) != 0) : ((rel < 8) ? mac_pat[rel] : 1'b1);
        #1;
        r0 = (g == 0) ? (mq.size() < 2) : (e0 && !b0.sop);
        r1 = (g == 1) ? (mq.size() < 2) : (e1 && !b1.sop);
        chk("in0_ready", 64'(in0_ready), 64'(r0));
        chk("in1_ready", 64'(in1_ready), 64'(r1));
        chk("tx_valid", 64'(avalon_st_tx_valid), 64'(mq.size() > 0));
        if (mq.size() > 0)
            chk("tx_beat", 64'({avalon_st_tx_data, avalon_st_tx_startofpacket,
                               avalon_st_tx_endofpacket, avalon_st_tx_empty,
                               avalon_st_tx_error}), 64'(mq[0]));
`ifdef ETH_TX_ARB_STATS_EN
        chk("stat_pkt0", 64'(stat_pkt0), 64'(m_pkt0));
        chk("stat_pkt1", 64'(stat_pkt1), 64'(m_pkt1));
        chk("stat_drop", 64'(stat_drop), 64'(m_drop));
`endif
        rh0.push_back(in0_ready);
        @(posedge clk);
        if (mq.size() > 0 && avalon_st_tx_ready) begin
            log_b.push_back(mq[0]);
            log_c.push_back(rel);
            void'(mq.pop_front());
        end
        a0 = e0 && r0;
        a1 = e1 && r1;
        if (g == 0 && a0) mq.push_back(b0);
        if (g == 1 && a1) mq.push_back(b1);
        if (g != 0 && a0 && m_drop != 16'hFFFF) m_drop++;
        if (g != 1 && a1 && m_drop != 16'hFFFF) m_drop++;
        if (g < 0) begin
            g = pick(e0 && b0.sop, e1 && b1.sop, last);
        end else if ((g == 0 && a0 && b0.eop) || (g == 1 && a1 && b1.eop)) begin
            if (g == 0) m_pkt0++;
            else m_pkt1++;
            last = (g == 1);
            g = pick(e0 && b0.sop, e1 && b1.sop, last);
        end
        if (a0) void'(s0.pop_front());
        if (a1) void'(s1.pop_front());
        rel++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        avalon_st_tx_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_readies", 64'({in0_ready, in1_ready}), 64'd0);
        chk("rst_tx", 64'({avalon_st_tx_valid, avalon_st_tx_data, avalon_st_tx_startofpacket,
                           avalon_st_tx_endofpacket, avalon_st_tx_empty, avalon_st_tx_error}),
            64'd0);
`ifdef ETH_TX_ARB_STATS_EN
        chk("rst_stats", 64'({stat_pkt1, stat_drop}) | 64'(stat_pkt0), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        g = -1;
        last = 1'b1;
        mq.delete();
        s0.delete();
        s1.delete();
        m_pkt0 = '0;
        m_pkt1 = '0;
        m_drop = '0;
    endtask

    task automatic chk_log(input int i, input logic [31:0] d, input int c);
        if (i < log_b.size()) begin
            chk("log_data", 64'(log_b[i].data), 64'(d));
            chk("log_cycle", 64'(log_c[i]), 64'(c));
        end else begin
            chk("log_missing", 64'(log_b.size()), 64'(i + 1));
        end
    endtask

    logic [31:0] d2_exp[7];
    logic [15:0] drop_before;

    initial begin
        rst_n = 1'b0;
        {in0_data, in0_startofpacket, in0_endofpacket, in0_empty, in0_error, in0_valid} = '0;
        {in1_data, in1_startofpacket, in1_endofpacket, in1_empty, in1_error, in1_valid} = '0;
        avalon_st_tx_ready = 1'b0;
        rel = 0;
        do_reset(3);

        // Single 5-beat packet on in0, MAC always ready.
        start_test();
        add_pkt(0, 32'hA000_0000, 5, 2'd2, 1'b0);
        repeat (10) step(1'b0);
        chk("d1_count", 64'(log_b.size()), 64'd5);
        chk_log(0, 32'hA000_0000, 2);
        chk_log(4, 32'hA000_0004, 6);
        if (log_b.size() == 5) begin
            chk("d1_sop", 64'(log_b[0].sop), 64'd1);
            chk("d1_eop_empty", 64'({log_b[4].eop, log_b[4].empty}), 64'h6);
        end

        // Simultaneous sop after reset: in0, then in1, then in0 back-to-back.
        do_reset(1);
        start_test();
        add_pkt(0, 32'hB000_0000, 3, 2'd0, 1'b0);
        add_pkt(0, 32'hC000_0000, 2, 2'd1, 1'b1);
        add_pkt(1, 32'hD000_0000, 2, 2'd3, 1'b0);
        d2_exp = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hD000_0000,
                   32'hD000_0001, 32'hC000_0000, 32'hC000_0001};
        repeat (12) step(1'b0);
        chk("d2_count", 64'(log_b.size()), 64'd7);
        for (int i = 0; i < 7; i++) chk_log(i, d2_exp[i], i + 2);

        // MAC ready 1,0,0,1 during a 3-beat packet.
        start_test();
        mac_pat[2] = 1'b0;
        mac_pat[3] = 1'b0;
        add_pkt(0, 32'hE000_0000, 3, 2'd0, 1'b0);
        repeat (10) step(1'b0);
        chk("d3_count", 64'(log_b.size()), 64'd3);
        chk_log(0, 32'hE000_0000, 4);
        chk_log(1, 32'hE000_0001, 5);
        chk_log(2, 32'hE000_0002, 6);
        chk("d3_rdy", 64'({rh0[2], rh0[3], rh0[4], rh0[5]}), 64'b1001);

        // in1 beat without sop while in0 holds the grant is dropped.
        start_test();
        drop_before = m_drop;
        add_pkt(0, 32'hF000_0000, 3, 2'd0, 1'b0);
        s1.push_back(beat_t'({32'hEEEE_EEEE, 5'b00000}));
        start1 = 2;
        repeat (8) step(1'b0);
        chk("d4_drop", 64'(m_drop - drop_before), 64'd1);
        chk("d4_src1_left", 64'(s1.size()), 64'd0);
        chk("d4_count", 64'(log_b.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk_log(i, 32'hF000_0000 + 32'(i), i + 2);

        // Reset mid-packet, then a fresh packet.
        start_test();
        add_pkt(0, 32'h6000_0000, 4, 2'd0, 1'b0);
        repeat (3) step(1'b0);
        do_reset(1);
        start_test();
        add_pkt(0, 32'h7000_0000, 2, 2'd1, 1'b0);
        repeat (6) step(1'b0);
        chk("d5_count", 64'(log_b.size()), 64'd2);
        chk_log(0, 32'h7000_0000, 2);
        chk_log(1, 32'h7000_0001, 3);

`ifdef ETH_TX_ARB_STATS_EN
        // Packet count wraps from all-ones to zero.
        start_test();
        @(negedge clk);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        avalon_st_tx_ready = 1'b0;
        force dut.stat_pkt0_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_pkt0_q;
        m_pkt0 = 32'hFFFF_FFFF;
        add_pkt(0, 32'h5000_0000, 1, 2'd0, 1'b0);
        repeat (5) step(1'b0);
        chk("pkt0_wrap_model", 64'(m_pkt0), 64'd0);
        chk("pkt0_wrap", 64'(stat_pkt0), 64'd0);
`endif

        // Randomized traffic, junk beats and MAC backpressure.
        start_test();
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                int r;
                r = $urandom_range(0, 15);
                if (((n == 0) ? s0.size() : s1.size()) == 0) begin
                    if (r < 4)
                        add_pkt(n, $urandom, $urandom_range(1, 5), 2'($urandom),
                                1'($urandom_range(0, 7) == 0));
                    else if (r == 4)
                        add_pkt(n, $urandom, 2, 2'd0, 1'b0);
                    else if (r == 5) begin
                        if (n == 0) s0.push_back(beat_t'({$urandom, 1'b0, 4'($urandom)}));
                        else s1.push_back(beat_t'({$urandom, 1'b0, 4'($urandom)}));
                    end
                end
            end
            step(1'b1);
        end
        s0.delete();
        s1.delete();
        repeat (5) step(1'b0);
        chk("final_drain", 64'(mq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
